// File: rtl/snn_pkg.sv
// Shared definitions for the SNN readout and its neighbours (LIF core, bench).
package snn_pkg;

  // Default geometry: neuron count, class count and time steps per frame.
  localparam int unsigned SNN_N      = 96;
  localparam int unsigned SNN_C      = 12;
  localparam int unsigned SNN_WINDOW = 100;

  // Readout FSM: accumulate a frame, scan classes, hold the result.
  typedef enum logic [1:0] {
    StAccum,
    StScan,
    StHold
  } readout_state_e;

endpackage

// File: rtl/snn_class_sum.sv
// Combinational sum of the G spike counters belonging to one class.
module snn_class_sum #(
  parameter int unsigned G  = 8,
  parameter int unsigned CW = 7,
  parameter int unsigned SW = 10
) (
  input  logic [G*CW-1:0] i_cnt,
  output logic [SW-1:0]   o_sum
);

  // Zero-extend each counter to SW bits so the total never truncates.
  always_comb begin
    o_sum = '0;
    for (int g = 0; g < G; g++) begin
      o_sum = o_sum + SW'(i_cnt[g*CW +: CW]);
    end
  end

endmodule

// File: rtl/snn_readout.sv
// Spike-count readout: accumulates WINDOW steps per frame, then picks the class
// with the largest total spike count (lowest index wins ties) and holds it
// until the consumer accepts it.
module snn_readout
  import snn_pkg::*;
#(
  parameter int unsigned N      = SNN_N,
  parameter int unsigned C      = SNN_C,
  parameter int unsigned WINDOW = SNN_WINDOW,
  localparam int unsigned G  = N / C,
  localparam int unsigned CW = $clog2(WINDOW + 1),
  localparam int unsigned SW = $clog2(G * WINDOW + 1),
  localparam int unsigned IW = (C > 1) ? $clog2(C) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          step_valid,
  input  logic [N-1:0]  spikes_vec,
  input  logic          frame_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] class_id,
  output logic [SW-1:0] class_score,
  output logic          drop_err
);

  readout_state_e       r_state, w_state_next;
  logic [N-1:0][CW-1:0] r_cnt;
  logic [CW-1:0]        r_stp, w_stp_next;
  logic [IW-1:0]        r_k, w_k_next;
  logic [IW-1:0]        r_best_id, w_best_id_next;
  logic [SW-1:0]        r_best_score, w_best_score_next;
  logic [IW-1:0]        r_class_id, w_class_id_next;
  logic [SW-1:0]        r_class_score, w_class_score_next;
  logic                 r_drop_err, w_drop_err_next;
  logic                 w_accept;   // step is counted into cnt
  logic                 w_clear;    // cnt is wiped on the next edge
  logic                 w_take;     // current class replaces the best
  logic [G*CW-1:0]      w_sel;
  logic [SW-1:0]        w_score;

  // Class-index multiplexer: contiguous block of G counters for class r_k.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < C; k++) begin
      if (r_k == IW'(k)) w_sel = r_cnt[k*G +: G];
    end
  end

  snn_class_sum #(
    .G  (G),
    .CW (CW),
    .SW (SW)
  ) u_class_sum (
    .i_cnt (w_sel),
    .o_sum (w_score)
  );

  // Next-state logic; frame_clr overrides everything, including the handshake.
  always_comb begin
    w_state_next       = r_state;
    w_stp_next         = r_stp;
    w_k_next           = r_k;
    w_best_id_next     = r_best_id;
    w_best_score_next  = r_best_score;
    w_class_id_next    = r_class_id;
    w_class_score_next = r_class_score;
    w_drop_err_next    = r_drop_err;
    w_accept           = 1'b0;
    w_clear            = 1'b0;
    // Class 0 seeds the best candidate unconditionally.
    w_take             = (r_k == '0) || (w_score > r_best_score);

    if (frame_clr) begin
      w_state_next = StAccum;
      w_stp_next   = '0;
      w_clear      = 1'b1;
    end else begin
      case (r_state)
        StAccum: begin
          if (step_valid) begin
            w_accept   = 1'b1;
            w_stp_next = r_stp + 1'b1;
            if (r_stp == CW'(WINDOW - 1)) begin
              w_state_next = StScan;
              w_k_next     = '0;
            end
          end
        end
        StScan: begin
          if (step_valid) w_drop_err_next = 1'b1;
          if (w_take) begin
            w_best_id_next    = r_k;
            w_best_score_next = w_score;
          end
          if (r_k == IW'(C - 1)) begin
            w_state_next       = StHold;
            w_class_id_next    = w_take ? r_k : r_best_id;
            w_class_score_next = w_take ? w_score : r_best_score;
          end else begin
            w_k_next = r_k + 1'b1;
          end
        end
        StHold: begin
          if (step_valid) w_drop_err_next = 1'b1;
          if (out_ready) begin
            w_state_next = StAccum;
            w_stp_next   = '0;
            w_clear      = 1'b1;
          end
        end
        default: w_state_next = StAccum;
      endcase
    end
  end

  // FSM state and scan/result registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= StAccum;
      r_stp         <= '0;
      r_k           <= '0;
      r_best_id     <= '0;
      r_best_score  <= '0;
      r_class_id    <= '0;
      r_class_score <= '0;
      r_drop_err    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_stp         <= w_stp_next;
      r_k           <= w_k_next;
      r_best_id     <= w_best_id_next;
      r_best_score  <= w_best_score_next;
      r_class_id    <= w_class_id_next;
      r_class_score <= w_class_score_next;
      r_drop_err    <= w_drop_err_next;
    end
  end

  // Per-neuron spike counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_clear) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      for (int n = 0; n < N; n++) begin
        r_cnt[n] <= r_cnt[n] + CW'(spikes_vec[n]);
      end
    end
  end

  assign out_valid   = (r_state == StHold);
  assign class_id    = r_class_id;
  assign class_score = r_class_score;
  assign drop_err    = r_drop_err;

endmodule
